aes_block_packer: RTL and testbench

//  Packs the UART RX byte stream into 128-bit plaintext blocks for the AES encrypt stage.

---
 rtl/aes_block_packer.sv | 111 +++++++++++
 tb/tb_aes_block_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes_block_packer.sv
// Packs UART RX bytes into BLOCK_BYTES-wide plaintext blocks and hands them to AES on valid/ready.
// Optional partial-block idle timeout is compiled in when AES_PACK_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no bytes held, byte_count = 0
// FILL  | 1..BLOCK_BYTES-1 bytes held
// FULL  | complete block presented, block_valid = 1
module aes_block_packer #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  input  logic                               block_ready,
  output logic [8*BLOCK_BYTES-1:0]           block_out,
  output logic                               block_valid,
  output logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_count,
  output logic                               overrun
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  if (BLOCK_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aes_block_packer: BLOCK_BYTES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t state;

  logic timeout;

`ifdef AES_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_tmr;
  logic          accept;
  logic          to_full;

  assign accept  = rx_valid && (state != FULL || block_ready);
  assign to_full = rx_valid && state != FULL && byte_count == LAST;
  assign timeout = (state == FILL) && !rx_valid && (idle_tmr == TW'(1));

  // Down-counter reloaded on each accepted byte; terminal count 1 ends the partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_tmr <= '0;
    end else if (accept && !to_full) begin
      idle_tmr <= TW'(TIMEOUT_CYCLES);
    end else if (state == FILL && !to_full) begin
      if (idle_tmr != '0) idle_tmr <= idle_tmr - TW'(1);
    end else begin
      idle_tmr <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      block_out   <= '0;
      block_valid <= 1'b0;
      byte_count  <= '0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (rx_valid) begin
            block_out  <= {block_out[BW-9:0], rx_data};
            byte_count <= byte_count + CW'(1);
            if (byte_count == LAST) begin
              state       <= FULL;
              block_valid <= 1'b1;
            end else begin
              state <= FILL;
            end
          end else if (timeout) begin
            state      <= IDLE;
            byte_count <= '0;
          end
        end
        FULL: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            // A byte arriving on the handshake cycle starts the next block.
            if (rx_valid) begin
              block_out  <= {block_out[BW-9:0], rx_data};
              byte_count <= CW'(1);
              state      <= FILL;
            end else begin
              byte_count <= '0;
              state      <= IDLE;
            end
          end else if (rx_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          block_valid <= 1'b0;
          byte_count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: stimulus queues expected blocks, a negedge monitor
// pops and compares them on every handshake; register-level checks are made inline.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         block_ready;
  logic [127:0] block_out;
  logic         block_valid;
  logic [4:0]   byte_count;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_block_packer #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .block_ready(block_ready),
    .block_out  (block_out),
    .block_valid(block_valid),
    .byte_count (byte_count),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && block_valid && block_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL block unexpected actual=%h required=none", block_out);
      end else begin
        chk("block", block_out, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
  endtask

  task automatic send_seq(input logic [7:0] base, input logic [7:0] step, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) idle(gap);
      send_byte(base + step * 8'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    block_ready = 1'b0;
    idle(3);
    chk("reset_block_out", block_out, 128'h0);
    chk("reset_valid", {127'h0, block_valid}, 128'h0);
    chk("reset_count", {123'h0, byte_count}, 128'h0);
    chk("reset_overrun", {127'h0, overrun}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: 0x00..0xFF, gaps of 3, ready held high
    block_ready = 1'b1;
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    send_seq(8'h00, 8'h11, 16, 3);
    chk("t1_valid", {127'h0, block_valid}, 128'h1);
    chk("t1_count16", {123'h0, byte_count}, 128'd16);
    idle(1);
    chk("t1_valid_drop", {127'h0, block_valid}, 128'h0);
    chk("t1_count0", {123'h0, byte_count}, 128'd0);

    // 2: back-pressure for 20 cycles
    block_ready = 1'b0;
    exp_q.push_back(128'h202122232425262728292a2b2c2d2e2f);
    send_seq(8'h20, 8'h01, 16, 0);
    for (int i = 0; i < 20; i++) begin
      chk("t2_hold_valid", {127'h0, block_valid}, 128'h1);
      chk("t2_hold_block", block_out, 128'h202122232425262728292a2b2c2d2e2f);
      idle(1);
    end
    block_ready = 1'b1;
    idle(1);
    chk("t2_valid_drop", {127'h0, block_valid}, 128'h0);
    chk("t2_overrun", {127'h0, overrun}, 128'h0);

    // 4: byte arrives on the handshake cycle
    block_ready = 1'b0;
    exp_q.push_back(128'h505152535455565758595a5b5c5d5e5f);
    send_seq(8'h50, 8'h01, 16, 0);
    idle(2);
    block_ready = 1'b1;
    send_byte(8'h5c);
    chk("t4_valid", {127'h0, block_valid}, 128'h0);
    chk("t4_count1", {123'h0, byte_count}, 128'd1);
    exp_q.push_back(128'h5c6162636465666768696a6b6c6d6e6f);
    send_seq(8'h61, 8'h01, 15, 1);
    chk("t4_top_byte", {120'h0, block_out[127:120]}, 128'h5c);
    chk("t4_overrun", {127'h0, overrun}, 128'h0);
    idle(1);

    // 3: overrun while FULL
    block_ready = 1'b0;
    exp_q.push_back(128'h303132333435363738393a3b3c3d3e3f);
    send_seq(8'h30, 8'h01, 16, 0);
    send_byte(8'haa);
    chk("t3_overrun", {127'h0, overrun}, 128'h1);
    chk("t3_block_kept", block_out, 128'h303132333435363738393a3b3c3d3e3f);
    chk("t3_count16", {123'h0, byte_count}, 128'd16);
    block_ready = 1'b1;
    idle(1);
    exp_q.push_back(128'h404142434445464748494a4b4c4d4e4f);
    send_seq(8'h40, 8'h01, 16, 0);
    idle(1);
    chk("t3_count0", {123'h0, byte_count}, 128'd0);
    chk("t3_overrun_sticky", {127'h0, overrun}, 128'h1);

    // 5: asynchronous reset mid-fill
    send_seq(8'he0, 8'h01, 7, 0);
    chk("t5_count7", {123'h0, byte_count}, 128'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_block", block_out, 128'h0);
    chk("t5_rst_count", {123'h0, byte_count}, 128'd0);
    chk("t5_rst_overrun", {127'h0, overrun}, 128'h0);
    chk("t5_rst_valid", {127'h0, block_valid}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(128'h707172737475767778797a7b7c7d7e7f);
    send_seq(8'h70, 8'h01, 16, 2);
    idle(1);
    chk("t5_overrun", {127'h0, overrun}, 128'h0);

    // 6: idle timeout on a partial block
    send_seq(8'h80, 8'h01, 5, 0);
    idle(49);
    chk("t6_before_timeout", {123'h0, byte_count}, 128'd5);
    idle(1);
`ifdef AES_PACK_TIMEOUT_EN
    chk("t6_timeout_count", {123'h0, byte_count}, 128'd0);
    exp_q.push_back(128'h909192939495969798999a9b9c9d9e9f);
    send_seq(8'h90, 8'h01, 16, 0);
`else
    chk("t6_no_timeout_count", {123'h0, byte_count}, 128'd5);
    exp_q.push_back(128'h8081828384909192939495969798999a);
    send_seq(8'h90, 8'h01, 11, 0);
`endif
    idle(1);
    chk("t6_count0", {123'h0, byte_count}, 128'd0);

    idle(3);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
